// File: rtl/sw_key_event_ctrl_pkg.sv
// sw_key_event_ctrl_pkg: shared event, register map and local-bus types for the key/switch controller
package sw_key_event_ctrl_pkg;
    localparam int NUM_KEYS = 4;
    localparam int NUM_SW = 3;
    localparam int NUM_IN = NUM_KEYS + NUM_SW;
    typedef struct packed {
        logic       level;
        logic [2:0] idx;
    } key_evt_t;
    localparam logic [15:0] REG_KEY = 16'h0;
    localparam logic [15:0] REG_SW = 16'h2;
    localparam logic [15:0] REG_EVT = 16'h4;
    localparam logic [15:0] REG_CTRL = 16'h6;
    localparam int ST_IRQ_EN = 0;
    localparam int ST_OVF = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_CNT_W = 4;
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } lb_slave_t;
    function automatic logic MatchRLB(lb_slave_t lb, logic [15:0] addr);
        return lb.rd && lb.addr == addr;
    endfunction
    function automatic logic MatchWLB(lb_slave_t lb, logic [15:0] addr);
        return lb.wr && lb.addr == addr;
    endfunction
endpackage

// File: rtl/sw_key_event_ctrl_debounce.sv
// sw_key_debounce: 2-FF synchroniser plus hold counter for one input; chg_o pulses on the accepting edge
module sw_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic chg_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic stable_q, diff;
    assign diff = sync_q[1] ^ stable_q;
    assign chg_o = diff && cnt_q == LAST;
    assign cnt_d = (diff && !chg_o) ? cnt_q + CW'(1) : '0;
    assign stable_o = stable_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q <= cnt_d;
            if (chg_o) stable_q <= sync_q[1];
        end
    end
endmodule

// File: rtl/sw_key_event_ctrl.sv
// sw_key_event_ctrl: debounced key/switch sampler with a prioritised event FIFO and interrupt on the local bus
module sw_key_event_ctrl
    import sw_key_event_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        lb_clk,
    input  logic        rst_n,
    input  lb_slave_t   xt_lb,
    output logic [15:0] rdata,
    input  logic [3:0]  key_raw,
    input  logic [2:0]  sw_raw,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [NUM_IN-1:0] in_raw, stable, chg, pend_q, pend_d;
    key_evt_t mem_q [FIFO_DEPTH];
    key_evt_t evt, head;
    logic [AW:0] wr_ptr_q, rd_ptr_q, count;
    logic [15:0] ctrl_word;
    logic irq_en_q, ovf_q, irq_q, empty, full, any_pend, push, pop, drop, wr_ctrl, ovf_clr;
    logic unused_wdata;

    assign in_raw = {sw_raw, ~key_raw};
    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        sw_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_i(lb_clk), .rst_ni(rst_n), .raw_i(in_raw[i]),
            .stable_o(stable[i]), .chg_o(chg[i])
        );
    end

    // lowest pending index wins; clearing the lowest set bit retires it
    always_comb begin
        evt = '0;
        for (int k = NUM_IN - 1; k >= 0; k--)
            if (pend_q[k]) evt = {stable[k], 3'(k)};
    end
    assign pend_d = (pend_q & (pend_q - NUM_IN'(1))) | chg;
    assign any_pend = |pend_q;
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = count == '0;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign pop = MatchRLB(xt_lb, REG_EVT) && !empty;
    assign push = any_pend && (!full || pop);
    assign drop = any_pend && full && !pop;
    assign wr_ctrl = MatchWLB(xt_lb, REG_CTRL);
    assign ovf_clr = wr_ctrl && xt_lb.wdata[ST_OVF];
    assign head = mem_q[rd_ptr_q[AW-1:0]];
    assign unused_wdata = ^xt_lb.wdata[15:2];

    always_comb begin
        ctrl_word = '0;
        ctrl_word[ST_IRQ_EN] = irq_en_q;
        ctrl_word[ST_OVF] = ovf_q;
        ctrl_word[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
    end

    assign rdata = MatchRLB(xt_lb, REG_KEY) ? {12'b0, stable[3:0]} :
                   MatchRLB(xt_lb, REG_SW) ? {13'b0, stable[6:4]} :
                   pop ? {1'b1, 11'b0, head} :
                   MatchRLB(xt_lb, REG_CTRL) ? ctrl_word : '0;
    assign irq = irq_q;

    always_ff @(posedge lb_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= evt;
    end

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            irq_en_q <= 1'b0;
            ovf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (wr_ctrl) irq_en_q <= xt_lb.wdata[ST_IRQ_EN];
            ovf_q <= drop || (ovf_q && !ovf_clr);
            irq_q <= irq_en_q && (!empty || ovf_q);
        end
    end
endmodule
